// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CH independent programmable clock-enable dividers sharing one config slot.
// Optional feature: define CLKDIV_ALIGN_EN to add the align input (phase-reset of all channels).

module clk_div_bank_ch #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_align,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_load_div,
    output logic             o_run,
    output logic             o_wrap,
    output logic             o_tick,
    output logic             o_clk_out
);
    localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
    localparam logic [DIV_W:0]   ONE_X = (DIV_W+1)'(1);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic             r_tick;
    logic             r_clk_out;
    logic             w_run;
    logic             w_last;
    logic [DIV_W:0]   w_high_len;

    assign w_run      = i_en && (r_div != '0);
    assign w_last     = (r_cnt == r_div - ONE);
    // One bit wider so that ceil(div/2) stays correct at the maximum divisor.
    assign w_high_len = ({1'b0, r_div} + ONE_X) >> 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_div     <= DIV_W'(DEFAULT_DIV);
            r_tick    <= 1'b0;
            r_clk_out <= 1'b0;
        end else begin
            r_tick    <= w_run && w_last;
            r_clk_out <= w_run && ({1'b0, r_cnt} < w_high_len);
            if (i_load) begin
                r_div <= i_load_div;
                r_cnt <= '0;
            end else if (i_align || !w_run || w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + ONE;
            end
        end
    end

    assign o_run     = w_run;
    assign o_wrap    = w_run && w_last;
    assign o_tick    = r_tick;
    assign o_clk_out = r_clk_out;
endmodule

module clk_div_bank #(
    parameter  int NUM_CH      = 2,
    parameter  int DIV_W       = 16,
    parameter  int DEFAULT_DIV = 5,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
`ifdef CLKDIV_ALIGN_EN
    input  logic              align,
`endif
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out
);
    localparam logic [CH_W:0] NUM_CH_X = (CH_W+1)'(NUM_CH);

    logic              r_live;
    logic              r_pend_vld;
    logic [CH_W-1:0]   r_pend_ch;
    logic [DIV_W-1:0]  r_pend_div;
    logic              w_align;
    logic              w_accept;
    logic              w_ch_ok;
    logic              w_apply;
    logic [NUM_CH-1:0] w_run;
    logic [NUM_CH-1:0] w_wrap;
    logic [NUM_CH-1:0] w_load;

`ifdef CLKDIV_ALIGN_EN
    assign w_align = align;
`else
    assign w_align = 1'b0;
`endif

    assign cfg_ready = r_live && !r_pend_vld;
    assign w_accept  = cfg_valid && cfg_ready;
    assign w_ch_ok   = ({1'b0, cfg_ch} < NUM_CH_X);
    // A stopped channel has no period to finish, so it takes the new divisor at once.
    assign w_apply   = r_pend_vld &&
                       (w_align || !w_run[r_pend_ch] || w_wrap[r_pend_ch]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live     <= 1'b0;
            r_pend_vld <= 1'b0;
            r_pend_ch  <= '0;
            r_pend_div <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_apply) begin
                r_pend_vld <= 1'b0;
            end else if (w_accept && w_ch_ok) begin
                r_pend_vld <= 1'b1;
                r_pend_ch  <= cfg_ch;
                r_pend_div <= cfg_div;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_load[g] = w_apply && (r_pend_ch == CH_W'(g));

        clk_div_bank_ch #(
            .DIV_W      (DIV_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_en      (ch_en[g]),
            .i_align   (w_align),
            .i_load    (w_load[g]),
            .i_load_div(r_pend_div),
            .o_run     (w_run[g]),
            .o_wrap    (w_wrap[g]),
            .o_tick    (tick[g]),
            .o_clk_out (clk_out[g])
        );
    end
endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: period-position model checked every cycle, plus directed literal checks.
// Exercises the align input too when CLKDIV_ALIGN_EN is defined.

module tb_clk_div_bank;
    localparam int NCH = 3;
    localparam int DW  = 16;
    localparam int CW  = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] ch_en;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [CW-1:0]  cfg_ch;
    logic [DW-1:0]  cfg_div;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] clk_out;
    logic           al;
`ifdef CLKDIV_ALIGN_EN
    logic           align;
    assign al = align;
`else
    assign al = 1'b0;
`endif

    clk_div_bank #(.NUM_CH(NCH), .DIV_W(DW), .DEFAULT_DIV(5)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef CLKDIV_ALIGN_EN
        .align    (align),
`endif
        .ch_en    (ch_en),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .tick     (tick),
        .clk_out  (clk_out)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: each channel tracks how many edges into its current period it is.
    int  m_div [NCH];
    int  m_pos [NCH];
    bit  m_tick[NCH];
    bit  m_clk [NCH];
    bit  run_v [NCH];
    bit  end_v [NCH];
    bit  m_live, m_pend, apply_v, accept_v;
    int  m_pch, m_pdiv;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_div[c] = 5; m_pos[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
            end
            m_live = 0; m_pend = 0; m_pch = 0; m_pdiv = 0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                run_v[c]  = (ch_en[c] === 1'b1) && (m_div[c] != 0);
                end_v[c]  = run_v[c] && (m_pos[c] == m_div[c] - 1);
                m_tick[c] = end_v[c];
                m_clk[c]  = run_v[c] && (2 * m_pos[c] < m_div[c]);
            end
            apply_v  = m_pend && ((al === 1'b1) || !run_v[m_pch] || end_v[m_pch]);
            accept_v = (cfg_valid === 1'b1) && m_live && !m_pend;
            for (int c = 0; c < NCH; c++)
                if ((al === 1'b1) || !run_v[c] || end_v[c]) m_pos[c] = 0;
                else m_pos[c]++;
            if (apply_v) begin
                m_div[m_pch] = m_pdiv; m_pos[m_pch] = 0; m_pend = 0;
            end else if (accept_v && int'(cfg_ch) < NCH) begin
                m_pend = 1; m_pch = int'(cfg_ch); m_pdiv = int'(cfg_div);
            end
            m_live = 1;
        end
    end

    bit             chk_on = 0;
    logic [NCH-1:0] et, ec;
    always @(negedge clk) begin
        if (chk_on) begin
            for (int c = 0; c < NCH; c++) begin
                et[c] = m_tick[c];
                ec[c] = m_clk[c];
            end
            chk("model_tick", 32'(tick), 32'(et));
            chk("model_clk_out", 32'(clk_out), 32'(ec));
            chk("model_cfg_ready", 32'(cfg_ready), 32'(m_live && !m_pend));
        end
    end

    int tq[$];
    always @(negedge clk) if (tick[0] === 1'b1) tq.push_back(cyc);

    task automatic cfg_write(input int ch, input int dv);
        cfg_ch = CW'(ch); cfg_div = DW'(dv); cfg_valid = 1'b1;
        for (int t = 0; t < 50 && cfg_ready !== 1'b1; t++) @(negedge clk);
        chk("cfg_ready_wait", 32'(cfg_ready), 32'(1));
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    logic [9:0] cc, ct;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete by cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ch_en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
`ifdef CLKDIV_ALIGN_EN
        align = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk_on = 1;
        chk("rst_cfg_ready", 32'(cfg_ready), 32'(0));
        chk("rst_tick", 32'(tick), 32'(0));
        chk("rst_clk_out", 32'(clk_out), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(cfg_ready), 32'(1));

        // Default divisor 5: high 3, low 2, tick on the last low cycle
        ch_en[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); cc[k] = clk_out[0]; ct[k] = tick[0];
        end
        chk("div5_clk_pattern", 32'(cc), 32'(10'b0011100111));
        chk("div5_tick_pattern", 32'(ct), 32'(10'b1000010000));

        // Mid-period reprogram to 8 at cnt=1; a second request waits behind it
        @(negedge clk);
        cfg_ch = 0; cfg_div = 8; cfg_valid = 1'b1;
        @(negedge clk);
        chk("ready_low_after_accept", 32'(cfg_ready), 32'(0));
        cfg_ch = 2; cfg_div = 2;
        for (int t = 0; t < 20 && cfg_ready !== 1'b1; t++) @(negedge clk);
        chk("ready_rise_with_old_tick", 32'({cfg_ready, tick[0]}), 32'(2'b11));
        @(negedge clk);
        cfg_valid = 1'b0;
        for (int t = 0; t < 40 && tq.size() < 5; t++) @(negedge clk);
        chk("tick_count", 32'(tq.size() >= 5), 32'(1));
        if (tq.size() >= 5) begin
            chk("old_period_len", 32'(tq[2] - tq[1]), 32'(5));
            chk("new_period_len_1", 32'(tq[3] - tq[2]), 32'(8));
            chk("new_period_len_2", 32'(tq[4] - tq[3]), 32'(8));
        end

        // Out-of-range channel: accepted and dropped
        cfg_write(3, 7);
        chk("ready_after_dropped_cfg", 32'(cfg_ready), 32'(1));

        // div=1 holds both outputs high
        cfg_write(1, 1);
        @(negedge clk);
        ch_en[1] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); cc[k] = clk_out[1]; ct[k] = tick[1];
        end
        chk("div1_clk", 32'(cc[5:0]), 32'(6'b111111));
        chk("div1_tick", 32'(ct[5:0]), 32'(6'b111111));

        // div=0 disables the channel
        cfg_write(1, 0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); cc[k] = clk_out[1]; ct[k] = tick[1];
        end
        chk("div0_clk", 32'(cc[3:0]), 32'(4'b0000));
        chk("div0_tick", 32'(ct[3:0]), 32'(4'b0000));

        // div=2 on ch2 (programmed earlier while it was stopped)
        ch_en[2] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); cc[k] = clk_out[2]; ct[k] = tick[2];
        end
        chk("div2_clk", 32'(cc[5:0]), 32'(6'b010101));
        chk("div2_tick", 32'(ct[5:0]), 32'(6'b101010));

        // Drop ch0 enable at cnt=3, then restart from 0
        for (int t = 0; t < 20 && tick[0] !== 1'b1; t++) @(negedge clk);
        chk("wait_ch0_tick", 32'(tick[0]), 32'(1));
        repeat (3) @(negedge clk);
        chk("ch0_high_before_drop", 32'(clk_out[0]), 32'(1));
        ch_en[0] = 1'b0;
        @(negedge clk);
        chk("ch0_off_after_drop", 32'({clk_out[0], tick[0]}), 32'(0));
        ch_en[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); cc[k] = clk_out[0]; ct[k] = tick[0];
        end
        chk("restart_div8_clk", 32'(cc[7:0]), 32'(8'b00001111));
        chk("restart_div8_tick", 32'(ct[7:0]), 32'(8'b10000000));

        // Reset with a pending entry: divisor back to 5, entry lost
        cfg_write(0, 3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ready", 32'(cfg_ready), 32'(0));
        chk("async_rst_outputs", 32'({tick, clk_out}), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); cc[k] = clk_out[0]; ct[k] = tick[0];
        end
        chk("post_rst_clk_pattern", 32'(cc), 32'(10'b0011100111));
        chk("post_rst_tick_pattern", 32'(ct), 32'(10'b1000010000));

`ifdef CLKDIV_ALIGN_EN
        cfg_write(0, 4);
        cfg_write(1, 4);
        ch_en[1] = 1'b0;
        @(negedge clk);
        ch_en[1] = 1'b1;
        repeat (6) @(negedge clk);
        align = 1'b1;
        @(negedge clk);
        align = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); cc[k] = clk_out[0]; ct[k] = tick[1];
        end
        chk("align_ch0_clk", 32'(cc[7:0]), 32'(8'b00110011));
        chk("align_ch1_tick", 32'(ct[7:0]), 32'(8'b10001000));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
